instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch -- instruction fetch unit with a small prefetch queue.
//
// Issues sequential word reads to instruction memory and keeps at most one read
// outstanding. Returned words go into a DEPTH-entry FIFO that feeds decode. A
// redirect (taken branch/jump) flushes the FIFO and restarts fetching at the
// new address. If a read is still in flight when the redirect arrives, the
// read is allowed to finish and its data is dropped.
//
// Parameters
//   RESET_PC     first fetch address after reset
//   DEPTH        prefetch queue entries (power of two, 2..16)
//
// Ports
//   clock        sole clock, rising-edge
//   reset        synchronous, active-high
//   imem_req     registered read request
//   imem_addr    word-aligned read address, valid while imem_req is high
//   imem_ack     memory completes the request this cycle (only counts when
//                imem_req is high)
//   imem_rdata   instruction word, valid with imem_ack
//   dec_valid    queue head holds an instruction for decode
//   dec_instr    instruction at the queue head
//   dec_pc       address of dec_instr
//   dec_ready    decode takes the head this cycle
//   redirect     flush the queue and refetch from redirect_pc
//   redirect_pc  new fetch address, bits [1:0] ignored
//   fetch_count  count of instructions handed to decode (only when the
//                INSTR_FETCH_PERF_EN macro is defined)
//
// Build option
//   INSTR_FETCH_PERF_EN  adds the fetch_count port and its counter.
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        dec_valid,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  input  logic        dec_ready,
  input  logic        redirect,
`ifdef INSTR_FETCH_PERF_EN
  input  logic [31:0] redirect_pc,
  output logic [31:0] fetch_count
`else
  input  logic [31:0] redirect_pc
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // IDLE: no read in flight. WAIT: read in flight, data will be kept.
  // DROP: read in flight, data will be thrown away (a redirect overtook it).
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  state_t           state_q, state_d;
  logic             req_q;
  logic [31:0]      addr_q;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      redirect_target;

  entry_t           queue_mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;

  logic             ack_ok;
  logic             push;
  logic             pop;

  // ---------------------------------------------------------------------------
  // Handshake qualifiers
  // ---------------------------------------------------------------------------
  // An ack only means something while our own request is up.
  assign ack_ok = req_q & imem_ack;
  assign pop    = dec_valid & dec_ready;
  // Data is kept only when it belongs to the current fetch stream.
  assign push   = (state_q == ST_WAIT) & ack_ok & ~redirect;
  // Masking keeps every redirect_pc bit in use while forcing word alignment.
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

  // ---------------------------------------------------------------------------
  // Queue occupancy and fetch address for the next cycle
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    count_d = count_q;
    if (redirect) begin
      // A pop in the redirect cycle is irrelevant: everything is flushed.
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect) begin
      fetch_pc_d = redirect_target;
    end else if (push) begin
      // Plain 32-bit add: FFFF_FFFC wraps to 0000_0000.
      fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        // A redirect empties the queue, so it always leaves room to fetch.
        if (redirect || (count_q < FULL_CNT)) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect) begin
          // With the ack in hand the old read is already done; otherwise it
          // must still be drained.
          state_d = ack_ok ? ST_WAIT : ST_DROP;
        end else if (ack_ok && (count_d >= FULL_CNT)) begin
          state_d = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (ack_ok) begin
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request, address, fetch PC and queue pointers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      req_q      <= (state_d != ST_IDLE);
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      // In DROP the in-flight address must stay on the bus until its ack.
      if (state_d != ST_DROP) begin
        addr_q <= fetch_pc_d;
      end
      if (redirect) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) begin
          wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
      end
    end
  end

  // NOTE: the queue storage has no reset; the pointers and count alone decide
  // which entries are meaningful, so clearing the array would buy nothing.
  always_ff @(posedge clock) begin
    if (push) begin
      queue_mem[wr_ptr_q] <= '{pc: fetch_pc_q, instr: imem_rdata};
    end
  end

  // ---------------------------------------------------------------------------
  // FSM / datapath outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    imem_req  = req_q;
    imem_addr = addr_q;
    dec_valid = (count_q != '0);
    dec_instr = queue_mem[rd_ptr_q].instr;
    dec_pc    = queue_mem[rd_ptr_q].pc;
  end

`ifdef INSTR_FETCH_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counter: instructions actually delivered to decode. A pop in a
  // redirect cycle is cancelled by the flush and is not counted.
  // ---------------------------------------------------------------------------
  logic [31:0] perf_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_q <= '0;
    end else if (pop && !redirect) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign fetch_count = perf_q;
`endif

endmodule
